// File: rtl/reg_file_param_pkg.sv
`default_nettype none
// ============================================================================
// Module : reg_file_param_pkg
// Desc   : Shared FSM encoding, default widths and packed-port slice helper.
// Rev    : 1.0
// ============================================================================

`ifndef RF_SLICE
`define RF_SLICE(idx, w) ((idx)*(w)) +: (w)
`endif

package reg_file_param_pkg;

    localparam int DEF_DATA_W = 32;
    localparam int DEF_ADDR_W = 5;

    typedef enum logic [0:0] {
        ST_IDLE  = 1'b0,
        ST_CLEAR = 1'b1
    } rf_state_e;

endpackage

`default_nettype wire

// File: rtl/reg_file_rd_port.sv
`default_nettype none
// ============================================================================
// Module : reg_file_rd_port
// Desc   : One registered read port: zero-register check, bypass mux, output flop.
// Rev    : 1.0
// ============================================================================

module reg_file_rd_port
    import reg_file_param_pkg::*;
#(
    parameter int DATA_W   = DEF_DATA_W,
    parameter int ADDR_W   = DEF_ADDR_W,
    parameter int ZERO_REG = 1,
    parameter int BYPASS   = 1
) (
    input  logic              clk,
    input  logic              reset,
    input  logic              rd_en,
    input  logic [ADDR_W-1:0] rd_addr,
    input  logic [DATA_W-1:0] mem_data,
    input  logic              wr_en,
    input  logic [ADDR_W-1:0] wr_addr,
    input  logic [DATA_W-1:0] wr_data,
    output logic [DATA_W-1:0] rd_data
);

    logic [DATA_W-1:0] rd_data_nxt;

    // Zero-register check has priority so bypass never leaks data out of entry 0.
    always_comb begin
        rd_data_nxt = mem_data;
        if (!rd_en) begin
            rd_data_nxt = '0;
        end else if ((ZERO_REG != 0) && (rd_addr == '0)) begin
            rd_data_nxt = '0;
        end else if ((BYPASS != 0) && wr_en && (wr_addr == rd_addr)) begin
            rd_data_nxt = wr_data;
        end
    end

    always_ff @(posedge clk or negedge reset) begin
        if (!reset) begin
            rd_data <= '0;
        end else begin
            rd_data <= rd_data_nxt;
        end
    end

endmodule

`default_nettype wire

// File: rtl/reg_file_param.sv
`default_nettype none
// ============================================================================
// Module : reg_file_param
// Desc   : Parametrised register file, one write port, NUM_RD registered reads,
//          with a sequential clear engine after reset or on request.
// Rev    : 1.0
// ============================================================================

module reg_file_param
    import reg_file_param_pkg::*;
#(
    parameter int DATA_W   = DEF_DATA_W,
    parameter int ADDR_W   = DEF_ADDR_W,
    parameter int NUM_RD   = 2,
    parameter int ZERO_REG = 1,
    parameter int BYPASS   = 1
) (
    input  logic                     clk,
    input  logic                     reset,
    input  logic                     clear_req,
    output logic                     busy,
    input  logic                     wr_en,
    input  logic [ADDR_W-1:0]        wr_addr,
    input  logic [DATA_W-1:0]        wr_data,
    input  logic [NUM_RD*ADDR_W-1:0] rd_addr,
    output logic [NUM_RD*DATA_W-1:0] rd_data
);

    localparam int                DEPTH    = 1 << ADDR_W;
    localparam logic [ADDR_W-1:0] CNT_LAST = '1;

    rf_state_e         state;
    rf_state_e         state_nxt;
    logic [ADDR_W-1:0] clr_cnt;
    logic [ADDR_W-1:0] clr_cnt_nxt;
    logic              idle;
    logic              user_we;
    logic              mem_we;
    logic [ADDR_W-1:0] mem_waddr;
    logic [DATA_W-1:0] mem_wdata;

    logic [DATA_W-1:0] mem [DEPTH];

    always_ff @(posedge clk or negedge reset) begin
        if (!reset) begin
            state   <= ST_CLEAR;
            clr_cnt <= '0;
        end else begin
            state   <= state_nxt;
            clr_cnt <= clr_cnt_nxt;
        end
    end

    always_comb begin
        state_nxt   = state;
        clr_cnt_nxt = clr_cnt;
        case (state)
            ST_CLEAR: begin
                if (clr_cnt == CNT_LAST) begin
                    state_nxt   = ST_IDLE;
                    clr_cnt_nxt = '0;
                end else begin
                    clr_cnt_nxt = clr_cnt + ADDR_W'(1);
                end
            end
            ST_IDLE: begin
                if (clear_req) begin
                    state_nxt   = ST_CLEAR;
                    clr_cnt_nxt = '0;
                end
            end
            default: begin
                state_nxt   = ST_CLEAR;
                clr_cnt_nxt = '0;
            end
        endcase
    end

    assign idle = (state == ST_IDLE);
    assign busy = ~idle;

    // Single physical write port shared by the clear engine and the user.
    assign user_we   = idle && wr_en && !((ZERO_REG != 0) && (wr_addr == '0));
    assign mem_we    = !idle || user_we;
    assign mem_waddr = idle ? wr_addr : clr_cnt;
    assign mem_wdata = idle ? wr_data : '0;

    always_ff @(posedge clk) begin
        if (mem_we) begin
            mem[mem_waddr] <= mem_wdata;
        end
    end

    for (genvar k = 0; k < NUM_RD; k++) begin : g_rd_port
        logic [ADDR_W-1:0] port_addr;
        logic [DATA_W-1:0] port_mem;

        assign port_addr = rd_addr[`RF_SLICE(k, ADDR_W)];
        assign port_mem  = mem[port_addr];

        reg_file_rd_port #(
            .DATA_W  (DATA_W),
            .ADDR_W  (ADDR_W),
            .ZERO_REG(ZERO_REG),
            .BYPASS  (BYPASS)
        ) u_rd_port (
            .clk     (clk),
            .reset   (reset),
            .rd_en   (idle),
            .rd_addr (port_addr),
            .mem_data(port_mem),
            .wr_en   (wr_en),
            .wr_addr (wr_addr),
            .wr_data (wr_data),
            .rd_data (rd_data[`RF_SLICE(k, DATA_W)])
        );
    end

endmodule

`default_nettype wire
